sdram_chip_model: RTL and testbench

//  Synthesizable responder for the 16-bit single-data-rate SDRAM command interface (W9864G6-class: 4 banks, 4096 rows, 256 columns).

---
 rtl/sdram_chip_if.sv | 23 ++
 rtl/sdram_chip_model.sv | 157 +++++++++++++++
 tb/tb_sdram_chip_model.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/sdram_chip_if.sv
// SDRAM command/data bus between a controller (master) and the chip responder (slave).
interface sdram_chip_if;
   logic [15:0] sd_dq_in;
   logic [15:0] sd_dq_out;
   logic [1:0]  sd_dq_oe;
   logic [11:0] sd_addr;
   logic [1:0]  sd_ba;
   logic [1:0]  sd_dqm;
   logic        sd_cs;
   logic        sd_ras;
   logic        sd_cas;
   logic        sd_we;

   modport master (
      output sd_dq_in, sd_addr, sd_ba, sd_dqm, sd_cs, sd_ras, sd_cas, sd_we,
      input  sd_dq_out, sd_dq_oe
   );

   modport slave (
      input  sd_dq_in, sd_addr, sd_ba, sd_dqm, sd_cs, sd_ras, sd_cas, sd_we,
      output sd_dq_out, sd_dq_oe
   );
endinterface

// File: rtl/sdram_chip_model.sv
// Synthesizable single-data-rate SDRAM chip responder: command decode, per-bank row
// tracking, mode register, byte-masked storage and CAS-latency read pipeline.
module sdram_chip_model #(
   parameter int unsigned MEM_AW = 14
) (
   input  logic         clk,
   input  logic         init,
   sdram_chip_if.slave  sd,
   output logic         mode_valid,
   output logic [1:0]   cas_lat,
   output logic [15:0]  refresh_cnt,
   output logic [3:0]   err
);
   localparam int unsigned NBANK     = 4;
   localparam int unsigned ROW_W     = 12;
   localparam int unsigned COL_W     = 8;
   localparam int unsigned DW        = 16;
   localparam int unsigned MEM_DEPTH = 2 ** MEM_AW;

   typedef enum logic [3:0] {
      CMD_INHIBIT = 4'b1111,
      CMD_NOP     = 4'b0111,
      CMD_ACTIVE  = 4'b0011,
      CMD_READ    = 4'b0101,
      CMD_WRITE   = 4'b0100,
      CMD_BST     = 4'b0110,
      CMD_PRE     = 4'b0010,
      CMD_REFRESH = 4'b0001,
      CMD_LMR     = 4'b0000
   } cmd_e;

   typedef enum logic {BANK_IDLE, BANK_ACTIVE} bank_state_e;

   bank_state_e       bank_state [NBANK];
   logic [ROW_W-1:0]  open_row   [NBANK];
   logic [7:0]        mem_hi     [MEM_DEPTH];
   logic [7:0]        mem_lo     [MEM_DEPTH];

   cmd_e              cmd_c;
   logic              all_idle_c;
   logic              access_ok_c;
   logic              rd_go_c;
   logic              wr_go_c;
   logic              mode_ok_c;
   logic [MEM_AW-1:0] mem_idx_c;

   // Read pipeline: slot 0 holds the READ edge, slot 1 the edge after.
   logic              s0_vld, s1_vld;
   logic              s0_lat3, s1_lat3;
   logic [1:0]        s0_oe, s1_oe;
   logic [DW-1:0]     s0_data, s1_data;

   // Command decode and access qualification.
   always_comb begin
      cmd_c       = sd.sd_cs ? CMD_INHIBIT : cmd_e'({sd.sd_cs, sd.sd_ras, sd.sd_cas, sd.sd_we});
      all_idle_c  = 1'b1;
      for (int i = 0; i < NBANK; i++) begin
         if (bank_state[i] == BANK_ACTIVE) all_idle_c = 1'b0;
      end
      access_ok_c = (bank_state[sd.sd_ba] == BANK_ACTIVE) && mode_valid;
      rd_go_c     = !init && (cmd_c == CMD_READ)  && access_ok_c;
      wr_go_c     = !init && (cmd_c == CMD_WRITE) && access_ok_c;
      mode_ok_c   = (sd.sd_addr[6:5] == 2'b01) && (sd.sd_addr[2:0] == 3'b000);
      mem_idx_c   = MEM_AW'({sd.sd_ba, open_row[sd.sd_ba], sd.sd_addr[COL_W-1:0]});
   end

   // Storage is never reset; the read captures the old word ahead of any later write.
   always_ff @(posedge clk) begin
      if (wr_go_c) begin
         if (!sd.sd_dqm[1]) mem_hi[mem_idx_c] <= sd.sd_dq_in[15:8];
         if (!sd.sd_dqm[0]) mem_lo[mem_idx_c] <= sd.sd_dq_in[7:0];
      end
      if (rd_go_c) s0_data <= {mem_hi[mem_idx_c], mem_lo[mem_idx_c]};
   end

   always_ff @(posedge clk) begin
      if (init) begin
         for (int i = 0; i < NBANK; i++) begin
            bank_state[i] <= BANK_IDLE;
            open_row[i]   <= '0;
         end
         s0_vld       <= 1'b0;
         s0_lat3      <= 1'b0;
         s0_oe        <= '0;
         s1_vld       <= 1'b0;
         s1_lat3      <= 1'b0;
         s1_oe        <= '0;
         s1_data      <= '0;
         sd.sd_dq_out <= '0;
         sd.sd_dq_oe  <= '0;
         mode_valid   <= 1'b0;
         cas_lat      <= 2'd2;
         refresh_cnt  <= '0;
         err          <= '0;
      end else begin
         s0_vld  <= rd_go_c;
         s0_lat3 <= (cas_lat == 2'd3);
         s0_oe   <= ~sd.sd_dqm;
         s1_vld  <= s0_vld;
         s1_lat3 <= s0_lat3;
         s1_oe   <= s0_oe;
         s1_data <= s0_data;

         if (s1_vld && s1_lat3) begin
            sd.sd_dq_out <= s1_data;
            sd.sd_dq_oe  <= s1_oe;
         end else if (s0_vld && !s0_lat3) begin
            sd.sd_dq_out <= s0_data;
            sd.sd_dq_oe  <= s0_oe;
         end else begin
            sd.sd_dq_out <= '0;
            sd.sd_dq_oe  <= '0;
         end

         case (cmd_c)
            CMD_ACTIVE: begin
               if (bank_state[sd.sd_ba] == BANK_IDLE) begin
                  bank_state[sd.sd_ba] <= BANK_ACTIVE;
                  open_row[sd.sd_ba]   <= sd.sd_addr;
               end else begin
                  err[0] <= 1'b1;
               end
            end
            CMD_READ, CMD_WRITE: begin
               if (!access_ok_c)        err[1] <= 1'b1;
               else if (sd.sd_addr[10]) bank_state[sd.sd_ba] <= BANK_IDLE;
            end
            CMD_BST: begin
               s0_vld       <= 1'b0;
               s1_vld       <= 1'b0;
               sd.sd_dq_out <= '0;
               sd.sd_dq_oe  <= '0;
            end
            CMD_PRE: begin
               if (sd.sd_addr[10]) begin
                  for (int i = 0; i < NBANK; i++) bank_state[i] <= BANK_IDLE;
               end else begin
                  bank_state[sd.sd_ba] <= BANK_IDLE;
               end
            end
            CMD_REFRESH: begin
               if (all_idle_c) refresh_cnt <= refresh_cnt + 16'd1;
               else            err[2] <= 1'b1;
            end
            CMD_LMR: begin
               if (!all_idle_c)     err[2] <= 1'b1;
               else if (!mode_ok_c) err[3] <= 1'b1;
               else begin
                  cas_lat    <= sd.sd_addr[5:4];
                  mode_valid <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_sdram_chip_model.sv
// Directed bench for sdram_chip_model: init sequence, byte masks, CAS latency, errors, reset mid-read.
module tb_sdram_chip_model;
   localparam logic [3:0] C_NOP  = 4'b0111;
   localparam logic [3:0] C_ACT  = 4'b0011;
   localparam logic [3:0] C_RD   = 4'b0101;
   localparam logic [3:0] C_WR   = 4'b0100;
   localparam logic [3:0] C_BST  = 4'b0110;
   localparam logic [3:0] C_PRE  = 4'b0010;
   localparam logic [3:0] C_REF  = 4'b0001;
   localparam logic [3:0] C_LMR  = 4'b0000;

   logic        clk = 1'b0;
   logic        init;
   logic        mode_valid;
   logic [1:0]  cas_lat;
   logic [15:0] refresh_cnt;
   logic [3:0]  err;
   int          passed = 0;
   int          total  = 0;

   sdram_chip_if sd ();

   sdram_chip_model #(.MEM_AW(14)) dut (
      .clk         (clk),
      .init        (init),
      .sd          (sd.slave),
      .mode_valid  (mode_valid),
      .cas_lat     (cas_lat),
      .refresh_cnt (refresh_cnt),
      .err         (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Drive one command for one edge, then return the bus to NOP 1ns after that edge.
   task automatic issue(input logic [3:0] c, input logic [1:0] ba, input logic [11:0] a,
                        input logic [1:0] dqm, input logic [15:0] d);
      {sd.sd_cs, sd.sd_ras, sd.sd_cas, sd.sd_we} = c;
      sd.sd_ba    = ba;
      sd.sd_addr  = a;
      sd.sd_dqm   = dqm;
      sd.sd_dq_in = d;
      @(posedge clk);
      #1;
      {sd.sd_cs, sd.sd_ras, sd.sd_cas, sd.sd_we} = C_NOP;
      sd.sd_dqm = 2'b00;
   endtask

   task automatic nop();
      issue(C_NOP, 2'd0, 12'h000, 2'b00, 16'h0000);
   endtask

   initial begin
      init = 1'b1;
      {sd.sd_cs, sd.sd_ras, sd.sd_cas, sd.sd_we} = 4'b1111;
      sd.sd_ba = '0; sd.sd_addr = '0; sd.sd_dqm = '0; sd.sd_dq_in = '0;
      @(posedge clk); @(posedge clk); #1;
      init = 1'b0;
      chk("rst_oe",   32'(sd.sd_dq_oe), 32'h0);
      chk("rst_dq",   32'(sd.sd_dq_out), 32'h0);
      chk("rst_mv",   32'(mode_valid), 32'h0);
      chk("rst_cl",   32'(cas_lat), 32'h2);
      chk("rst_ref",  32'(refresh_cnt), 32'h0);
      chk("rst_err",  32'(err), 32'h0);

      // Init sequence
      issue(C_PRE, 2'd0, 12'h400, 2'b00, 16'h0);
      for (int i = 0; i < 8; i++) issue(C_REF, 2'd0, 12'h000, 2'b00, 16'h0);
      issue(C_LMR, 2'd0, 12'h220, 2'b00, 16'h0);
      chk("init_mv",  32'(mode_valid), 32'h1);
      chk("init_cl",  32'(cas_lat), 32'h2);
      chk("init_ref", 32'(refresh_cnt), 32'h8);
      chk("init_err", 32'(err), 32'h0);

      // Write / precharge / reopen / read at CAS 2
      issue(C_ACT, 2'd1, 12'h123, 2'b00, 16'h0);
      issue(C_WR,  2'd1, 12'h045, 2'b00, 16'hBEEF);
      issue(C_PRE, 2'd1, 12'h000, 2'b00, 16'h0);
      issue(C_ACT, 2'd1, 12'h123, 2'b00, 16'h0);
      issue(C_RD,  2'd1, 12'h045, 2'b00, 16'h0);
      chk("cl2_oe_t0", 32'(sd.sd_dq_oe), 32'h0);
      nop();
      chk("cl2_dq",    32'(sd.sd_dq_out), 32'hBEEF);
      chk("cl2_oe",    32'(sd.sd_dq_oe), 32'h3);
      nop();
      chk("cl2_oe_off", 32'(sd.sd_dq_oe), 32'h0);

      // Byte masks
      issue(C_WR, 2'd1, 12'h045, 2'b10, 16'h1234);
      issue(C_RD, 2'd1, 12'h045, 2'b00, 16'h0);
      nop();
      chk("mask_dq", 32'(sd.sd_dq_out), 32'hBE34);
      nop();
      issue(C_RD, 2'd1, 12'h045, 2'b01, 16'h0);
      nop();
      chk("mask_oe",  32'(sd.sd_dq_oe), 32'h2);
      chk("mask_dq2", 32'(sd.sd_dq_out), 32'hBE34);
      nop();

      // CAS 3 and back-to-back reads
      issue(C_PRE, 2'd0, 12'h400, 2'b00, 16'h0);
      issue(C_LMR, 2'd0, 12'h230, 2'b00, 16'h0);
      chk("cl3_cl", 32'(cas_lat), 32'h3);
      issue(C_ACT, 2'd1, 12'h123, 2'b00, 16'h0);
      issue(C_WR,  2'd1, 12'h000, 2'b00, 16'h1111);
      issue(C_WR,  2'd1, 12'h001, 2'b00, 16'h2222);
      issue(C_RD,  2'd1, 12'h000, 2'b00, 16'h0);
      issue(C_RD,  2'd1, 12'h001, 2'b00, 16'h0);
      chk("cl3_oe_t1", 32'(sd.sd_dq_oe), 32'h0);
      nop();
      chk("cl3_dq0", 32'(sd.sd_dq_out), 32'h1111);
      chk("cl3_oe0", 32'(sd.sd_dq_oe), 32'h3);
      nop();
      chk("cl3_dq1", 32'(sd.sd_dq_out), 32'h2222);
      nop();
      chk("cl3_oe_off", 32'(sd.sd_dq_oe), 32'h0);

      // Protocol errors
      issue(C_RD, 2'd2, 12'h000, 2'b00, 16'h0);
      chk("err_rd_idle", 32'(err), 32'h2);
      nop(); nop();
      chk("err_rd_oe", 32'(sd.sd_dq_oe), 32'h0);
      issue(C_ACT, 2'd1, 12'h055, 2'b00, 16'h0);
      chk("err_act", 32'(err), 32'h3);
      issue(C_REF, 2'd0, 12'h000, 2'b00, 16'h0);
      chk("err_ref", 32'(err), 32'h7);
      chk("err_ref_cnt", 32'(refresh_cnt), 32'h8);
      issue(C_PRE, 2'd0, 12'h400, 2'b00, 16'h0);
      issue(C_LMR, 2'd0, 12'h221, 2'b00, 16'h0);
      chk("err_lmr", 32'(err), 32'hF);
      chk("err_lmr_cl", 32'(cas_lat), 32'h3);

      // Burst terminate drops a pending read
      issue(C_ACT, 2'd1, 12'h123, 2'b00, 16'h0);
      issue(C_RD,  2'd1, 12'h000, 2'b00, 16'h0);
      issue(C_BST, 2'd0, 12'h000, 2'b00, 16'h0);
      chk("bst_oe1", 32'(sd.sd_dq_oe), 32'h0);
      nop();
      chk("bst_oe2", 32'(sd.sd_dq_oe), 32'h0);

      // Reset mid-read, then re-init and confirm storage survived
      issue(C_RD, 2'd1, 12'h045, 2'b00, 16'h0);
      init = 1'b1;
      nop();
      init = 1'b0;
      chk("mid_oe",  32'(sd.sd_dq_oe), 32'h0);
      chk("mid_mv",  32'(mode_valid), 32'h0);
      chk("mid_err", 32'(err), 32'h0);
      chk("mid_cl",  32'(cas_lat), 32'h2);
      nop();
      chk("mid_oe2", 32'(sd.sd_dq_oe), 32'h0);
      issue(C_PRE, 2'd0, 12'h400, 2'b00, 16'h0);
      issue(C_LMR, 2'd0, 12'h220, 2'b00, 16'h0);
      issue(C_ACT, 2'd1, 12'h123, 2'b00, 16'h0);
      issue(C_RD,  2'd1, 12'h045, 2'b00, 16'h0);
      nop();
      chk("keep_dq", 32'(sd.sd_dq_out), 32'hBE34);
      chk("keep_oe", 32'(sd.sd_dq_oe), 32'h3);
      nop();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
